// File: rtl/intr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl_pkg
// Brief    : Shared CPU package for the interrupt responder: FSM encoding,
//            default handler-vector constants and a priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
package intr_ctrl_pkg;

    // Responder FSM encoding
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // Default handler vectors: source 0 at 0x800, 0x40 apart
    localparam logic [11:0] C_VEC_BASE   = 12'h800;
    localparam logic [11:0] C_VEC_STRIDE = 12'h040;

    // Priority encoder width; covers up to 8 sources
    localparam int C_PE_W     = 8;
    localparam int C_PE_IDX_W = 3;

    typedef struct packed {
        logic                  valid;
        logic [C_PE_IDX_W-1:0] idx;
    } pe_t;

    // Highest set bit index plus a valid flag
    function automatic pe_t prio_enc(input logic [C_PE_W-1:0] vec);
        pe_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int i = 0; i < C_PE_W; i++) begin
            if (vec[i]) begin
                r.valid = 1'b1;
                r.idx   = C_PE_IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/intr_ctrl_break_sync.sv
`default_nettype none
// ============================================================================
// Module   : break_sync
// Brief    : 2-FF synchroniser plus registered previous-value flop giving a
//            one-cycle rising-edge pulse per bit.
// Revision : 1.0 - initial release
// ============================================================================
module break_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;
    logic [2:0]       r_arm;

    // Synchroniser chain and previous-value flop
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Arms edge detection once the chain holds real samples, so a level that
    // is already high when reset releases is not mistaken for a new edge
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_arm <= '0;
        end else begin
            r_arm <= {r_arm[1:0], 1'b1};
        end
    end

    assign o_rise = r_sync & ~r_prev & {WIDTH{r_arm[2]}};

endmodule
`default_nettype wire

// File: rtl/intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl
// Brief    : Interrupt responder. Synchronises break inputs, latches rising
//            edges as pending requests, arbitrates by fixed priority, holds
//            irq until acknowledged and tracks in-service sources until eret.
//            Compile-time option INTR_NEST_EN enables priority nesting.
// Revision : 1.0 - initial release
// ============================================================================
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int               NUM_SRC    = 3,
    parameter int               VEC_W      = 12,
    parameter logic [VEC_W-1:0] VEC_BASE   = C_VEC_BASE,
    parameter logic [VEC_W-1:0] VEC_STRIDE = C_VEC_STRIDE
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] break_in,
    input  logic               int_en,
    input  logic               irq_ack,
    input  logic               eret,
    output logic               irq,
    output logic [VEC_W-1:0]   irq_vec,
    output logic [NUM_SRC-1:0] IW,
    output logic [NUM_SRC-1:0] ir_sig
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [C_PE_IDX_W-1:0] r_sel;
    logic [C_PE_IDX_W-1:0] w_sel_nxt;
    logic [NUM_SRC-1:0]    r_iw;
    logic [NUM_SRC-1:0]    r_ir;
    logic [NUM_SRC-1:0]    w_rise;
    logic [NUM_SRC-1:0]    w_elig_mask;
    logic [NUM_SRC-1:0]    w_cand;
    logic [NUM_SRC-1:0]    w_sel_oh;
    logic [NUM_SRC-1:0]    w_eret_clr;
    logic [NUM_SRC-1:0]    w_ack_set;
    logic                  w_ack_take;
    pe_t                   w_ir_pe;
    pe_t                   w_win_pe;

    break_sync #(
        .WIDTH (NUM_SRC)
    ) u_break_sync (
        .clk    (clk),
        .RST    (RST),
        .i_din  (break_in),
        .o_rise (w_rise)
    );

    // Eligibility, winner selection, ack one-hot and eret clear mask
    always_comb begin
        w_elig_mask = '0;
        w_sel_oh    = '0;
        w_eret_clr  = '0;
        w_ir_pe     = prio_enc(C_PE_W'(r_ir));
        for (int i = 0; i < NUM_SRC; i++) begin
`ifdef INTR_NEST_EN
            w_elig_mask[i] = !w_ir_pe.valid || (C_PE_IDX_W'(i) > w_ir_pe.idx);
`else
            w_elig_mask[i] = !w_ir_pe.valid;
`endif
            w_sel_oh[i]   = (r_sel == C_PE_IDX_W'(i));
            w_eret_clr[i] = eret && w_ir_pe.valid && (w_ir_pe.idx == C_PE_IDX_W'(i));
        end
        w_cand    = r_iw & w_elig_mask & {NUM_SRC{int_en}};
        w_win_pe  = prio_enc(C_PE_W'(w_cand));
        w_ack_take = irq_ack && (r_state == ST_REQ);
        w_ack_set = w_sel_oh & {NUM_SRC{w_ack_take}};
    end

    // Next-state: latch the winner on entry to REQ, hold it until ack
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        case (r_state)
            ST_IDLE: begin
                if (w_win_pe.valid) begin
                    w_state_nxt = ST_REQ;
                    w_sel_nxt   = w_win_pe.idx;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state and selected source registers
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // Pending and in-service flags; a new edge beats the ack clear, and eret
    // acts on the in-service set as it stood before this cycle's ack
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_iw <= '0;
            r_ir <= '0;
        end else begin
            r_iw <= (r_iw & ~w_ack_set) | w_rise;
            r_ir <= (r_ir & ~w_eret_clr) | w_ack_set;
        end
    end

    assign irq     = (r_state == ST_REQ);
    assign irq_vec = irq ? (VEC_BASE + VEC_W'(r_sel) * VEC_STRIDE) : '0;
    assign IW      = r_iw;
    assign ir_sig  = r_ir;

endmodule
`default_nettype wire

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt responder between the board-level break sources and the pipelined CPU core. It synchronises the three break inputs and latches each rising edge as a pending request. It arbitrates by fixed priority and raises a single interrupt request with a 12-bit handler vector, holding it until the core acknowledges. It then tracks in-service sources until the core executes return-from-interrupt, and exports per-source waiting and in-service flags for the display and debug path.

## Interface
Parameters:
- NUM_SRC, 3: number of break sources; source NUM_SRC-1 has the highest priority.
- VEC_W, 12: handler-vector width, matching the instruction address width.
- VEC_BASE, 12'h800: handler vector of source 0.
- VEC_STRIDE, 12'h040: vector spacing per source.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- break_in  in  NUM_SRC  raw asynchronous break levels, one per source.
- int_en  in  1  core global interrupt enable.
- irq_ack  in  1  core takes the interrupt; one-cycle pulse.
- eret  in  1  core return-from-interrupt; one-cycle pulse.
- irq  out  1  interrupt request to the core.
- irq_vec  out  VEC_W  handler address; valid while irq=1.
- IW  out  NUM_SRC  pending (waiting) flag per source.
- ir_sig  out  NUM_SRC  in-service flag per source.

## Operation
- Each break_in bit passes a 2-FF synchroniser followed by a registered previous-value flop. edge[i] = sync2[i] & ~prev[i].
- edge[i] sets IW[i]. An edge on a source that is already pending is merged; requests are not counted.
- Eligible source: the highest-index i with IW[i]=1 and i above the highest in-service index (nesting rule, see Configuration). int_en must also be 1.
- FSM states:
  - IDLE: irq=0. Moves to REQ when an eligible source exists; the winner index is latched into sel.
  - REQ: irq=1, irq_vec = VEC_BASE + sel*VEC_STRIDE (modulo 2^VEC_W).
    - sel and irq_vec stay stable until irq_ack, even if a higher source becomes pending. A later higher-priority source is taken on the next arbitration.
    - On irq_ack: clear IW[sel], set ir_sig[sel], go to IDLE.
    - int_en has no effect while in REQ; the request is never withdrawn.
- eret clears the highest-index set ir_sig bit. eret with ir_sig=0 is ignored.
- Simultaneous events:
  - edge[i] in the same cycle as the irq_ack clearing IW[i]: IW[i] ends at 1 (set wins).
  - irq_ack and eret in the same cycle: both apply, eret acting on ir_sig as it was before the ack.
  - irq_ack outside REQ: ignored.
- Reset, asserted at any time including mid-REQ: synchronisers, IW, ir_sig, sel, irq and irq_vec all go to 0; FSM goes to IDLE.

## Timing
- A break_in high level is first sampled at edge E0. edge[i] is true after E1, IW[i]=1 after E2, and irq=1 after E3 (when eligible). Worst-case latency is 4 clocks.
- irq_ack sampled at edge N: irq=0, IW[sel]=0 and ir_sig[sel]=1 after N. The earliest re-raise of irq is after N+1.
- eret takes effect on ir_sig at the same edge.
- Outputs are registered, except irq_vec, which is decoded from registered sel and gated by irq.

## Configuration
- INTR_NEST_EN defined: nesting is allowed. A pending source is eligible only if its index is greater than every set ir_sig index.
- INTR_NEST_EN undefined: no nesting. A source is eligible only while ir_sig is all zero.
- In both cases ir_sig keeps per-source bits and eret clears the highest set bit.

## Structure
- The shared CPU package holds:
  - the FSM state encoding (ST_IDLE=0, ST_REQ=1);
  - the default VEC_BASE and VEC_STRIDE constants;
  - a priority-encode function (highest set bit index plus a valid flag), which is reused by arbitration and eret clearing.
- One sub-module, break_sync: the parameterised 2-FF synchroniser plus rising-edge detector, instantiated once with width NUM_SRC.

## Test plan
- Reset release; break_in[0] high for 5 clocks, then low -> IW=3'b001 after 3 clocks, irq=1 with irq_vec=12'h800 one clock later. irq_ack -> IW=0, ir_sig=3'b001, irq=0. eret -> ir_sig=0.
- break_in[0] and break_in[2] rise in the same cycle -> irq_vec=12'h880 first. After ack, with INTR_NEST_EN: irq for 12'h800 only after eret.
- With INTR_NEST_EN, ir_sig=3'b001, then break_in[1] rises -> irq with irq_vec=12'h840, and ir_sig=3'b011 after ack. Two erets -> 3'b001, then 3'b000.
- Without INTR_NEST_EN, same stimulus -> irq stays 0 until eret, then 12'h840 is raised.
- A new edge on source 1 lands in the same cycle as its irq_ack -> IW[1]=1 afterwards, and a second request for 12'h840 follows once eligible.
- RST asserted while irq=1 and IW=3'b110 -> all outputs are 0 immediately (asynchronous). After release with break_in held high, no new request is raised (no rising edge).
